// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared state encodings for the sequential restoring divider
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_rbs_sub.sv
// rtl/seq_restoring_divider_rbs_sub.sv - N-bit ripple-borrow subtractor built from full-subtractor cells
module rbs_sub #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] d,
   output logic         bout
);

   logic [N:0] brw;

   assign brw[0] = bin;

   for (genvar i = 0; i < N; i++) begin : g_cell
      assign d[i]     = a[i] ^ b[i] ^ brw[i];
      assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
   end

   assign bout = brw[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             trial_neg;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   rbs_sub #(.N(WIDTH + 1)) u_sub (
      .a    ({r, q[WIDTH-1]}),
      .b    ({1'b0, d}),
      .bin  (1'b0),
      .d    (diff),
      .bout (borrow)
   );

   // A non-negative trial is below the divisor, so its top bit can only be set alongside a borrow.
   assign trial_neg = borrow | diff[WIDTH];

   always_comb begin
      r_next = trial_neg ? {r[WIDTH-2:0], q[WIDTH-1]} : diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], ~trial_neg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         count       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  d           <= divisor;
                  q           <= dividend;
                  r           <= '0;
                  count       <= '0;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     state       <= ST_DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= ST_CALC;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_CALC: begin
               q <= q_next;
               r <= r_next;
               if (count == LAST) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_next;
                  remainder <= r_next;
               end else begin
                  count <= count + CW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider at WIDTH=8
module tb_seq_restoring_divider;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   seq_restoring_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.q  = (b == 8'd0) ? 8'hFF : a / b;
      e.r  = (b == 8'd0) ? a : a % b;
      e.dz = (b == 8'd0);
      return e;
   endfunction

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      sb.push_back(model(a, b));
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         check({tag, "_done"}, done, 1'b1);
         check({tag, "_q"}, quotient, e.q);
         check({tag, "_r"}, remainder, e.r);
         check({tag, "_dz"}, div_by_zero, e.dz);
      end
   endtask

   // n counts the sample points after the accept edge until done appears; busy must be high before it.
   task automatic wait_done(output int n, output bit bad);
      n   = 1;
      bad = 1'b0;
      while (done !== 1'b1 && n < 40) begin
         if (busy !== 1'b1) bad = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (busy !== 1'b0) bad = 1'b1;
   endtask

   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b);
      int n;
      bit bad;
      push(a, b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n, bad);
      check({tag, "_latency"}, n, (b == 8'd0) ? 1 : 9);
      check({tag, "_busy"}, bad, 1'b0);
      check_result(tag);
      @(posedge clk); #1;
   endtask

   initial begin
      int         n;
      bit         bad;
      logic [7:0] a;
      logic [7:0] b;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_q", quotient, 8'd0);
      check("rst_r", remainder, 8'd0);
      check("rst_dz", div_by_zero, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("d200_7", 8'd200, 8'd7);

      // back-to-back with start held high
      push(8'd255, 8'd1);
      push(8'd5, 8'd9);
      dividend = 8'd255;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk); #1;
      dividend = 8'd5;
      divisor  = 8'd9;
      wait_done(n, bad);
      check("b2b_first_latency", n, 9);
      check("b2b_first_busy", bad, 1'b0);
      check_result("b2b_first");
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (done !== 1'b1 && n < 40);
      start = 1'b0;
      check("b2b_spacing", n, 10);
      check_result("b2b_second");
      @(posedge clk); #1;

      do_op("d13_0", 8'd13, 8'd0);

      // start pulse during CALC must be ignored; old results stay visible
      do_op("d5_9", 8'd5, 8'd9);
      push(8'd100, 8'd3);
      dividend = 8'd100;
      divisor  = 8'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_q_in_calc", quotient, 8'd0);
      check("hold_r_in_calc", remainder, 8'd5);
      wait_done(n, bad);
      check("ignore_busy", bad, 1'b0);
      check_result("ignore_start");
      @(posedge clk); #1;

      // reset mid-calculation
      dividend = 8'd200;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_q", quotient, 8'd0);
      check("abort_r", remainder, 8'd0);
      check("abort_dz", div_by_zero, 1'b0);
      do_op("d9_2", 8'd9, 8'd2);

      for (int i = 0; i < 1500; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         case (i % 10)
            0: b = 8'd1;
            1: a = 8'd0;
            2: begin
               a = 8'($urandom_range(0, 254));
               b = 8'($urandom_range(int'(a) + 1, 255));
            end
            3: b = 8'd0;
            default: ;
         endcase
         do_op("rand", a, b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
